// File: rtl/regfile_dump_reader_pkg.sv
// Shared definitions for the register-file dump reader: register-file
// geometry, dump FSM state encoding and the checksum fold helper.
package regfile_pkg;

    localparam int REG_COUNT  = 32;
    localparam int REG_ADDR_W = $clog2(REG_COUNT);
    localparam int XLEN       = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        SEND = 2'd2,
        FIN  = 2'd3
    } dump_state_t;

    // XOR-fold one register value into a running checksum.
    function automatic logic [XLEN-1:0] xor_fold(
        input logic [XLEN-1:0] acc,
        input logic [XLEN-1:0] data
    );
        return acc ^ data;
    endfunction

endpackage

// File: rtl/regfile_dump_reader_if.sv
// Valid/ready stream carrying (address, data, last) beats from the dump
// reader to the debug/trace sink.
interface regfile_dump_reader_if #(
    parameter int N      = 32,
    parameter int ADDR_W = 5
);
    logic              dump_valid_o;
    logic              dump_ready_i;
    logic [ADDR_W-1:0] dump_addr_o;
    logic [N-1:0]      dump_data_o;
    logic              dump_last_o;

    modport master (
        output dump_valid_o,
        input  dump_ready_i,
        output dump_addr_o,
        output dump_data_o,
        output dump_last_o
    );

    modport slave (
        input  dump_valid_o,
        output dump_ready_i,
        input  dump_addr_o,
        input  dump_data_o,
        input  dump_last_o
    );
endinterface

// File: rtl/regfile_dump_reader_out_reg.sv
// Output holding register for one dump beat. A load captures a beat and
// raises valid; a clear drops valid and last but keeps addr/data so the
// bus does not toggle needlessly after a handshake.
module dump_out_reg #(
    parameter int N      = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              clear,
    input  logic [ADDR_W-1:0] addr_in,
    input  logic [N-1:0]      data_in,
    input  logic              last_in,
    output logic              valid,
    output logic [ADDR_W-1:0] addr,
    output logic [N-1:0]      data,
    output logic              last
);

    // Beat register: clear has priority over load, otherwise hold.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid <= 1'b0;
            addr  <= '0;
            data  <= '0;
            last  <= 1'b0;
        end else if (clear) begin
            valid <= 1'b0;
            last  <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            addr  <= addr_in;
            data  <= data_in;
            last  <= last_in;
        end
    end

endmodule

// File: rtl/regfile_dump_reader.sv
// Register-file dump reader: on start, walks registers first..last through
// one combinational read port and streams (addr, data, last) beats over a
// valid/ready interface. One beat per two cycles with an always-ready sink.
// Optional feature macro: REGFILE_DUMP_CHECKSUM_EN adds checksum_o, the XOR
// of every handshaken data value of the current dump.
module regfile_dump_reader
    import regfile_pkg::*;
#(
    parameter int N      = XLEN,
    parameter int ADDR_W = REG_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start_i,
    input  logic              abort_i,
    input  logic [ADDR_W-1:0] first_reg_i,
    input  logic [ADDR_W-1:0] last_reg_i,
    output logic [ADDR_W-1:0] read_register_o,
    input  logic [N-1:0]      read_data_i,
    regfile_dump_reader_if.master dump,
    output logic              busy_o,
    output logic              done_o
`ifdef REGFILE_DUMP_CHECKSUM_EN
    ,
    output logic [N-1:0]      checksum_o
`endif
);

    dump_state_t       state_r;
    dump_state_t       next_state_s;
    logic [ADDR_W-1:0] cnt_r;
    logic [ADDR_W-1:0] cnt_next_s;
    logic [ADDR_W-1:0] last_r;
    logic [ADDR_W-1:0] last_next_s;
    logic              busy_r;
    logic              busy_next_s;
    logic              done_r;
    logic              done_next_s;
    logic [ADDR_W-1:0] read_reg_r;
    logic [ADDR_W-1:0] read_reg_next_s;
    logic              load_s;
    logic              clear_s;
    logic              handshake_s;

    assign handshake_s     = dump.dump_valid_o & dump.dump_ready_i;
    assign busy_o          = busy_r;
    assign done_o          = done_r;
    assign read_register_o = read_reg_r;

    // Next-state, counter and output-register control for the dump FSM.
    always_comb begin
        next_state_s = state_r;
        cnt_next_s   = cnt_r;
        last_next_s  = last_r;
        busy_next_s  = busy_r;
        load_s       = 1'b0;
        clear_s      = 1'b0;
        if (abort_i && busy_r) begin
            // Abort wins over everything, including a coincident handshake.
            next_state_s = IDLE;
            busy_next_s  = 1'b0;
            clear_s      = 1'b1;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start_i) begin
                        if (first_reg_i <= last_reg_i) begin
                            cnt_next_s   = first_reg_i;
                            last_next_s  = last_reg_i;
                            busy_next_s  = 1'b1;
                            next_state_s = READ;
                        end else begin
                            // Empty range: report completion without beats.
                            next_state_s = FIN;
                        end
                    end else begin
                        next_state_s = IDLE;
                    end
                end
                READ: begin
                    load_s       = 1'b1;
                    next_state_s = SEND;
                end
                SEND: begin
                    if (handshake_s) begin
                        clear_s = 1'b1;
                        if (dump.dump_last_o) begin
                            next_state_s = FIN;
                        end else begin
                            // cnt < last here, so the increment never wraps.
                            cnt_next_s   = cnt_r + ADDR_W'(1);
                            next_state_s = READ;
                        end
                    end else begin
                        next_state_s = SEND;
                    end
                end
                FIN: begin
                    busy_next_s  = 1'b0;
                    next_state_s = IDLE;
                end
                default: begin
                    busy_next_s  = 1'b0;
                    clear_s      = 1'b1;
                    next_state_s = IDLE;
                end
            endcase
        end
        done_next_s     = (next_state_s == FIN);
        read_reg_next_s = (next_state_s == READ) ? cnt_next_s : '0;
    end

    // FSM state, range counter and registered status outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= IDLE;
            cnt_r      <= '0;
            last_r     <= '0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            read_reg_r <= '0;
        end else begin
            state_r    <= next_state_s;
            cnt_r      <= cnt_next_s;
            last_r     <= last_next_s;
            busy_r     <= busy_next_s;
            done_r     <= done_next_s;
            read_reg_r <= read_reg_next_s;
        end
    end

    dump_out_reg #(
        .N      (N),
        .ADDR_W (ADDR_W)
    ) u_out_reg (
        .clk     (clk),
        .reset   (reset),
        .load    (load_s),
        .clear   (clear_s),
        .addr_in (cnt_r),
        .data_in (read_data_i),
        .last_in (cnt_r == last_r),
        .valid   (dump.dump_valid_o),
        .addr    (dump.dump_addr_o),
        .data    (dump.dump_data_o),
        .last    (dump.dump_last_o)
    );

`ifdef REGFILE_DUMP_CHECKSUM_EN
    logic [N-1:0] cks_r;
    logic         cks_clr_s;

    assign cks_clr_s  = (state_r == IDLE) && start_i;
    assign checksum_o = cks_r;

    // Checksum: cleared on an accepted start, folded on every handshake.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cks_r <= '0;
        end else if (cks_clr_s) begin
            cks_r <= '0;
        end else if (handshake_s) begin
            cks_r <= xor_fold(cks_r, dump.dump_data_o);
        end
    end
`endif

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Self-checking bench for regfile_dump_reader: a register-file model feeds
// the read port, expected beats go into a scoreboard queue when a dump is
// launched and are compared against the beats the sink accepts.
module tb_regfile_dump_reader;
    import regfile_pkg::*;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] addr;
        logic [XLEN-1:0]       data;
        logic                  last;
    } beat_t;

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  start_i;
    logic                  abort_i;
    logic [REG_ADDR_W-1:0] first_reg_i;
    logic [REG_ADDR_W-1:0] last_reg_i;
    logic [REG_ADDR_W-1:0] read_register_o;
    logic [XLEN-1:0]       read_data_i;
    logic                  busy_o;
    logic                  done_o;
`ifdef REGFILE_DUMP_CHECKSUM_EN
    logic [XLEN-1:0]       checksum_o;
    logic [XLEN-1:0]       cks_at_done;
`endif

    logic [XLEN-1:0] regs [REG_COUNT];
    assign read_data_i = regs[read_register_o];

    regfile_dump_reader_if #(.N(XLEN), .ADDR_W(REG_ADDR_W)) dif ();

    regfile_dump_reader dut (
        .clk             (clk),
        .reset           (reset),
        .start_i         (start_i),
        .abort_i         (abort_i),
        .first_reg_i     (first_reg_i),
        .last_reg_i      (last_reg_i),
        .read_register_o (read_register_o),
        .read_data_i     (read_data_i),
        .dump            (dif),
        .busy_o          (busy_o),
        .done_o          (done_o)
`ifdef REGFILE_DUMP_CHECKSUM_EN
        ,
        .checksum_o      (checksum_o)
`endif
    );

    always #5 clk = ~clk;

    int    checks = 0;
    int    errors = 0;
    beat_t exp_q [$];
    beat_t obs_q [$];
    int    done_cyc, done_count, first_valid_cyc, stall_err;
    bit    busy_seen, valid_seen, timed_out;
    logic  post_abort_valid, post_abort_busy;

    // Preload register model: x0 = 0, xi = 0xA0 + i.
    task automatic load_regs();
        for (int i = 0; i < REG_COUNT; i++) begin
            regs[i] = (i == 0) ? 32'h0 : (32'h0000_00A0 + 32'(i));
        end
    endtask

    // Push the expected beats of a range into the scoreboard.
    task automatic push_range(input int first, input int last);
        beat_t b;
        for (int i = first; i <= last; i++) begin
            b.addr = REG_ADDR_W'(i);
            b.data = regs[i];
            b.last = (i == last);
            exp_q.push_back(b);
        end
    endtask

    // Launch a dump and record what the sink sees; no checking here.
    task automatic run_dump(input int first, input int last, input int ready_mod,
                            input int abort_beat, input int budget);
        beat_t cur, prev;
        bit    prev_stall, aborted, fin, rdy;
        int    beats, abort_cyc;
        obs_q.delete();
        done_cyc = -1; done_count = 0; first_valid_cyc = -1; stall_err = 0;
        busy_seen = 1'b0; valid_seen = 1'b0; timed_out = 1'b0;
        post_abort_valid = 1'b1; post_abort_busy = 1'b1;
        prev_stall = 1'b0; aborted = 1'b0; fin = 1'b0; beats = 0; abort_cyc = 0;
        prev = '0;
        @(negedge clk);
        start_i = 1'b1; abort_i = 1'b0; dif.dump_ready_i = 1'b0;
        first_reg_i = REG_ADDR_W'(first); last_reg_i = REG_ADDR_W'(last);
        for (int c = 1; c <= budget && !fin; c++) begin
            @(negedge clk);
            start_i = 1'b0; abort_i = 1'b0;
            if (busy_o) busy_seen = 1'b1;
            if (done_o) begin
                done_count++;
                if (done_cyc < 0) done_cyc = c;
`ifdef REGFILE_DUMP_CHECKSUM_EN
                cks_at_done = checksum_o;
`endif
            end
            if (aborted && c == abort_cyc + 1) begin
                post_abort_valid = dif.dump_valid_o;
                post_abort_busy  = busy_o;
            end
            cur.addr = dif.dump_addr_o; cur.data = dif.dump_data_o; cur.last = dif.dump_last_o;
            if (dif.dump_valid_o) begin
                valid_seen = 1'b1;
                if (first_valid_cyc < 0) first_valid_cyc = c;
                if (prev_stall && cur !== prev) stall_err++;
            end
            rdy = (ready_mod > 0) && (c % ready_mod == 0);
            if (!aborted && abort_beat >= 0 && dif.dump_valid_o && beats == abort_beat) begin
                abort_i = 1'b1; rdy = 1'b0; aborted = 1'b1; abort_cyc = c;
            end
            dif.dump_ready_i = rdy;
            if (dif.dump_valid_o && rdy) begin
                obs_q.push_back(cur); beats++; prev_stall = 1'b0;
            end else begin
                prev_stall = dif.dump_valid_o;
            end
            prev = cur;
            if (done_cyc >= 0 && c >= done_cyc + 1) fin = 1'b1;
            if (aborted && c >= abort_cyc + 4) fin = 1'b1;
        end
        if (!fin) timed_out = 1'b1;
        dif.dump_ready_i = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; start_i = 1'b0; abort_i = 1'b0; dif.dump_ready_i = 1'b0;
        first_reg_i = '0; last_reg_i = '0;
        load_regs();
        @(negedge clk);
        checks++;
        if ({dif.dump_valid_o, busy_o, done_o, dif.dump_last_o, read_register_o, dif.dump_addr_o, dif.dump_data_o} !== '0) begin
            errors++;
            $display("FAIL reset_outputs valid=%b busy=%b done=%b last=%b rreg=%0d addr=%0d data=%h expected all 0",
                     dif.dump_valid_o, busy_o, done_o, dif.dump_last_o, read_register_o, dif.dump_addr_o, dif.dump_data_o);
        end
        reset = 1'b0;
    endtask

    task automatic test_basic();
        beat_t e, o;
        push_range(5, 7);
        run_dump(5, 7, 1, -1, 50);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                errors++; $display("FAIL basic_beat missing beat got none expected addr %0d", e.addr);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    errors++;
                    $display("FAIL basic_beat got addr=%0d data=%h last=%b expected addr=%0d data=%h last=%b",
                             o.addr, o.data, o.last, e.addr, e.data, e.last);
                end
            end
        end
        checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL basic_extra got %0d extra beats expected 0", obs_q.size()); end
        checks++; if (first_valid_cyc != 2) begin errors++; $display("FAIL basic_latency got %0d expected 2", first_valid_cyc); end
        checks++; if (done_cyc != 7) begin errors++; $display("FAIL basic_done_cycle got %0d expected 7", done_cyc); end
        checks++; if (done_count != 1) begin errors++; $display("FAIL basic_done_width got %0d expected 1", done_count); end
        checks++; if (read_register_o !== 5'd0) begin errors++; $display("FAIL basic_idle_rreg got %0d expected 0", read_register_o); end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL basic_idle_busy got %b expected 0", busy_o); end
    endtask

    task automatic test_full_range();
        beat_t e, o;
        push_range(0, 31);
        run_dump(0, 31, 3, -1, 400);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                errors++; $display("FAIL full_beat missing beat got none expected addr %0d", e.addr);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    errors++;
                    $display("FAIL full_beat got addr=%0d data=%h last=%b expected addr=%0d data=%h last=%b",
                             o.addr, o.data, o.last, e.addr, e.data, e.last);
                end
            end
        end
        checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL full_extra got %0d extra beats expected 0", obs_q.size()); end
        checks++; if (stall_err != 0) begin errors++; $display("FAIL full_stall_stable got %0d changes expected 0", stall_err); end
        checks++; if (done_count != 1 || timed_out) begin errors++; $display("FAIL full_done got count=%0d timeout=%b expected 1/0", done_count, timed_out); end
    endtask

    task automatic test_empty_range();
        run_dump(9, 3, 1, -1, 20);
        checks++; if (valid_seen) begin errors++; $display("FAIL empty_valid got 1 expected 0"); end
        checks++; if (busy_seen) begin errors++; $display("FAIL empty_busy got 1 expected 0"); end
        checks++; if (done_cyc != 1) begin errors++; $display("FAIL empty_done_cycle got %0d expected 1", done_cyc); end
        checks++; if (done_count != 1) begin errors++; $display("FAIL empty_done_width got %0d expected 1", done_count); end
    endtask

    task automatic test_abort();
        beat_t e, o;
        push_range(10, 12);
        e = exp_q.pop_back(); e.last = 1'b0; exp_q.push_back(e);
        run_dump(10, 20, 1, 3, 100);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                errors++; $display("FAIL abort_beat missing beat got none expected addr %0d", e.addr);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    errors++;
                    $display("FAIL abort_beat got addr=%0d data=%h last=%b expected addr=%0d data=%h last=%b",
                             o.addr, o.data, o.last, e.addr, e.data, e.last);
                end
            end
        end
        checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL abort_extra got %0d extra beats expected 0", obs_q.size()); end
        checks++; if (post_abort_valid !== 1'b0 || post_abort_busy !== 1'b0) begin
            errors++; $display("FAIL abort_idle got valid=%b busy=%b expected 0/0", post_abort_valid, post_abort_busy); end
        checks++; if (done_count != 0 || timed_out) begin errors++; $display("FAIL abort_no_done got count=%0d timeout=%b expected 0/0", done_count, timed_out); end
        checks++; if (dif.dump_last_o !== 1'b0) begin errors++; $display("FAIL abort_last got %b expected 0", dif.dump_last_o); end
        push_range(10, 10);
        run_dump(10, 10, 1, -1, 30);
        e = exp_q.pop_front();
        checks++;
        if (obs_q.size() != 1) begin
            errors++; $display("FAIL abort_restart_count got %0d beats expected 1", obs_q.size());
        end else begin
            o = obs_q.pop_front();
            if (o !== e) begin
                errors++;
                $display("FAIL abort_restart_beat got addr=%0d data=%h last=%b expected addr=%0d data=%h last=%b",
                         o.addr, o.data, o.last, e.addr, e.data, e.last);
            end
        end
        checks++; if (done_count != 1) begin errors++; $display("FAIL abort_restart_done got %0d expected 1", done_count); end
    endtask

    task automatic test_reset_mid();
        beat_t e, o;
        bit    got_valid;
        got_valid = 1'b0;
        @(negedge clk);
        start_i = 1'b1; first_reg_i = 5'd1; last_reg_i = 5'd2; dif.dump_ready_i = 1'b0;
        for (int c = 0; c < 20 && !got_valid; c++) begin
            @(negedge clk);
            start_i = 1'b0;
            if (dif.dump_valid_o) got_valid = 1'b1;
        end
        checks++;
        if (!got_valid) begin
            errors++; $display("FAIL reset_mid_wait got no valid expected valid within 20 cycles");
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({dif.dump_valid_o, busy_o, done_o, dif.dump_last_o, read_register_o, dif.dump_addr_o, dif.dump_data_o} !== '0) begin
            errors++;
            $display("FAIL reset_mid_outputs valid=%b busy=%b done=%b last=%b rreg=%0d addr=%0d data=%h expected all 0",
                     dif.dump_valid_o, busy_o, done_o, dif.dump_last_o, read_register_o, dif.dump_addr_o, dif.dump_data_o);
        end
        @(negedge clk);
        reset = 1'b0;
        push_range(1, 2);
        run_dump(1, 2, 1, -1, 30);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                errors++; $display("FAIL reset_mid_beat missing beat got none expected addr %0d", e.addr);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    errors++;
                    $display("FAIL reset_mid_beat got addr=%0d data=%h last=%b expected addr=%0d data=%h last=%b",
                             o.addr, o.data, o.last, e.addr, e.data, e.last);
                end
            end
        end
        checks++; if (done_cyc != 5) begin errors++; $display("FAIL reset_mid_done got %0d expected 5", done_cyc); end
    endtask

`ifdef REGFILE_DUMP_CHECKSUM_EN
    task automatic test_checksum();
        regs[1] = 32'h1; regs[2] = 32'h2; regs[3] = 32'h4;
        run_dump(1, 3, 1, -1, 30);
        checks++;
        if (done_count != 1 || cks_at_done !== 32'h7) begin
            errors++; $display("FAIL checksum got %h (done=%0d) expected 00000007", cks_at_done, done_count);
        end
        load_regs();
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_full_range();
        test_empty_range();
        test_abort();
        test_reset_mid();
`ifdef REGFILE_DUMP_CHECKSUM_EN
        test_checksum();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
